// File: rtl/mmu_pkg.sv
// Shared MMU array defaults, row classification type and psum row packing helper.
// Column c of a packed row lives at bits [c*MMU_PSUM_WIDTH +: MMU_PSUM_WIDTH].
package mmu_pkg;

  localparam int MMU_NUM_COL    = 4;
  localparam int MMU_PSUM_WIDTH = 32;

  typedef enum logic [1:0] {
    ROW_IDLE,
    ROW_FULL,
    ROW_PARTIAL
  } row_kind_t;

  function automatic logic [MMU_NUM_COL*MMU_PSUM_WIDTH-1:0] mmu_row_pack(
    input logic [MMU_NUM_COL-1:0][MMU_PSUM_WIDTH-1:0] cols
  );
    logic [MMU_NUM_COL*MMU_PSUM_WIDTH-1:0] row;
    row = '0;
    for (int c = 0; c < MMU_NUM_COL; c++) begin
      row[c*MMU_PSUM_WIDTH +: MMU_PSUM_WIDTH] = cols[c];
    end
    return row;
  endfunction

endpackage

// File: rtl/mmu_row_fifo.sv
// Sync row FIFO; write-to-read latency 1 cycle (no bypass), zero data when empty.
// Push is refused only when full with no pop in the same cycle; push+pop keeps count.
module mmu_row_fifo #(
  parameter int WIDTH = 136,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_dat_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           pop_dat_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push, do_pop;

  assign empty_o   = (cnt_q == '0);
  assign full_o    = (cnt_q == CNT_W'(DEPTH));
  assign count_o   = cnt_q;
  assign do_pop    = pop_i && !empty_o;
  assign do_push   = push_i && (!full_o || do_pop);
  assign pop_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: pop_dat_o is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/mmu_psum_collector.sv
// Deskews systolic column psums into aligned rows and queues them for writeback.
// Latency NUM_COL cycles from column 0 to out_valid_o; out_ready_i low holds rows, drops (overflow) when full.
module mmu_psum_collector
  import mmu_pkg::*;
#(
  parameter int NUM_COL    = MMU_NUM_COL,
  parameter int PSUM_WIDTH = MMU_PSUM_WIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter int ROW_CNT_W  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_COL*PSUM_WIDTH-1:0] psum_i,
  input  logic [NUM_COL-1:0]            psum_en_i,
  input  logic                          clear_i,
  output logic [NUM_COL*PSUM_WIDTH-1:0] out_data_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [ROW_CNT_W-1:0]          row_idx_o,
  output logic                          full_o,
  output logic                          overflow_o,
  output logic                          misalign_o
);

  localparam int DW    = NUM_COL * PSUM_WIDTH;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_COL-1:0]                 al_en;
  logic [NUM_COL-1:0][PSUM_WIDTH-1:0] al_dat;

  for (genvar c = 0; c < NUM_COL; c++) begin : g_deskew
    if (c == NUM_COL - 1) begin : g_direct
      assign al_en[c]  = psum_en_i[c];
      assign al_dat[c] = psum_i[c*PSUM_WIDTH +: PSUM_WIDTH];
    end else begin : g_delay
      localparam int D = NUM_COL - 1 - c;
      logic [D-1:0]                 en_q;
      logic [D-1:0][PSUM_WIDTH-1:0] dat_q;

      always_ff @(posedge clk) begin
        if (!rst_n || clear_i) begin
          en_q  <= '0;
          dat_q <= '0;
        end else begin
          en_q[0]  <= psum_en_i[c];
          dat_q[0] <= psum_i[c*PSUM_WIDTH +: PSUM_WIDTH];
          for (int i = 1; i < D; i++) begin
            en_q[i]  <= en_q[i-1];
            dat_q[i] <= dat_q[i-1];
          end
        end
      end

      assign al_en[c]  = en_q[D-1];
      assign al_dat[c] = dat_q[D-1];
    end
  end

  row_kind_t            row_kind;
  logic                 pop, push_req, room, push;
  logic [CNT_W-1:0]     fifo_cnt;
  logic                 fifo_full, fifo_empty;
  logic [ROW_CNT_W+DW-1:0] fifo_dat;
  logic [ROW_CNT_W-1:0] row_cnt_q, row_cnt_d;
  logic                 ovf_q, ovf_d, mis_q, mis_d;

  always_comb begin
    row_kind = ROW_IDLE;
    if (&al_en)      row_kind = ROW_FULL;
    else if (|al_en) row_kind = ROW_PARTIAL;
  end

  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign pop      = out_valid_o && out_ready_i;
  assign push_req = (row_kind == ROW_FULL);
  assign room     = (fifo_cnt != CNT_W'(FIFO_DEPTH)) || pop;
  assign push     = push_req && room;

  always_comb begin
    row_cnt_d = row_cnt_q;
    ovf_d     = ovf_q;
    mis_d     = mis_q;
    if (push)                    row_cnt_d = row_cnt_q + 1'b1;
    if (push_req && !room)       ovf_d     = 1'b1;
    if (row_kind == ROW_PARTIAL) mis_d     = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      row_cnt_q <= '0;
      ovf_q     <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      row_cnt_q <= row_cnt_d;
      ovf_q     <= ovf_d;
      mis_q     <= mis_d;
    end
  end

  mmu_row_fifo #(
    .WIDTH (ROW_CNT_W + DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (clear_i),
    .push_i     (push),
    .push_dat_i ({row_cnt_q, al_dat}),
    .pop_i      (pop),
    .pop_dat_o  (fifo_dat),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_cnt)
  );

  assign {row_idx_o, out_data_o} = fifo_dat;
  assign out_valid_o = !fifo_empty;
  assign full_o      = fifo_full;
  assign overflow_o  = ovf_q;
  assign misalign_o  = mis_q;

endmodule

// File: tb/tb_mmu_psum_collector.sv
// Bench for mmu_psum_collector: skewed wavefront driver, row scoreboard, enable-pattern table
// and hand-written backpressure / full+pop / reset-mid-stream sequences.
module tb_mmu_psum_collector;
  import mmu_pkg::*;

  localparam int NC = MMU_NUM_COL;
  localparam int PW = MMU_PSUM_WIDTH;
  localparam int FD = 4;
  localparam int RW = 8;
  localparam int DW = NC * PW;

  logic          clk = 1'b0;
  logic          rst_n, clear_i, out_ready_i;
  logic [DW-1:0] psum_i, out_data_o;
  logic [NC-1:0] psum_en_i;
  logic          out_valid_o, full_o, overflow_o, misalign_o;
  logic [RW-1:0] row_idx_o;

  mmu_psum_collector #(
    .NUM_COL(NC), .PSUM_WIDTH(PW), .FIFO_DEPTH(FD), .ROW_CNT_W(RW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .psum_i(psum_i), .psum_en_i(psum_en_i), .clear_i(clear_i),
    .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .row_idx_o(row_idx_o), .full_o(full_o), .overflow_o(overflow_o), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [RW-1:0] idx; logic [DW-1:0] dat; } exp_t;
  typedef struct { logic [NC-1:0] mask; logic exp_mis; int n_store; } vec_t;

  exp_t          exp_q[$];
  logic [RW-1:0] exp_row = '0;
  int checks = 0, failures = 0, cyc = 0;
  int pop_cnt = 0, first_pop = -1, last_pop = -1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [DW-1:0] row_of(input logic [31:0] base, input int w);
    logic [NC-1:0][PW-1:0] cols;
    for (int c = 0; c < NC; c++) cols[c] = base + PW'(w * 16 + c);
    return mmu_row_pack(cols);
  endfunction

  task automatic expect_row(input logic [DW-1:0] dat);
    exp_t e;
    e.idx = exp_row;
    e.dat = dat;
    exp_q.push_back(e);
    exp_row++;
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    exp_q.delete();
    exp_row = '0;
  endtask

  // Wavefront w presents column c at relative cycle w+c; only the first n_store rows are expected.
  task automatic wave(input int n, input logic [31:0] base, input logic [NC-1:0] mask,
                      input int n_store, input int ready_at);
    for (int t = 0; t < n + NC - 1; t++) begin
      if (t < n && t < n_store) expect_row(row_of(base, t));
      for (int c = 0; c < NC; c++) begin
        int w;
        w = t - c;
        if (w >= 0 && w < n) begin
          psum_i[c*PW +: PW] = base + PW'(w * 16 + c);
          psum_en_i[c]       = mask[c];
        end else begin
          psum_i[c*PW +: PW] = '0;
          psum_en_i[c]       = 1'b0;
        end
      end
      if (ready_at >= 0) out_ready_i = (t == ready_at);
      step();
    end
    psum_i    = '0;
    psum_en_i = '0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      step();
      n++;
    end
    chk(name, DW'(exp_q.size()), '0);
    step();
    chk({name, "_valid_low"}, out_valid_o, 1'b0);
  endtask

  always @(negedge clk) begin
    if (rst_n && !clear_i && out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_row actual=idx %0h data %0h required=no row (cycle %0d)",
                 row_idx_o, out_data_o, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("row_data", out_data_o, e.dat);
        chk("row_idx", DW'(row_idx_o), DW'(e.idx));
        pop_cnt++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
    end
  end

  initial begin
    vec_t tbl[6];
    int   pc0;
    tbl[0] = '{4'hF, 1'b0, 1};
    tbl[1] = '{4'hB, 1'b1, 0};
    tbl[2] = '{4'h0, 1'b0, 0};
    tbl[3] = '{4'h1, 1'b1, 0};
    tbl[4] = '{4'h8, 1'b1, 0};
    tbl[5] = '{4'h7, 1'b1, 0};

    rst_n = 1'b0; clear_i = 1'b0; out_ready_i = 1'b0; psum_i = '0; psum_en_i = '0;
    step();
    step();
    chk("rst_valid", out_valid_o, 1'b0);
    chk("rst_full", full_o, 1'b0);
    chk("rst_data", out_data_o, '0);
    chk("rst_idx", DW'(row_idx_o), '0);
    chk("rst_ovf", overflow_o, 1'b0);
    chk("rst_mis", misalign_o, 1'b0);
    rst_n = 1'b1;
    step();

    // Single skewed wavefront: valid exactly four cycles after column 0.
    out_ready_i = 1'b1;
    expect_row(row_of(32'h100, 0));
    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < NC; c++) begin
        psum_i[c*PW +: PW] = (i == c) ? PW'(32'h100 + c) : '0;
        psum_en_i[c]       = (i == c);
      end
      chk("wave_valid_cycle", out_valid_o, (i == 4));
      step();
    end
    psum_i = '0; psum_en_i = '0;
    chk("wave_drained", DW'(exp_q.size()), '0);

    // Back-to-back wavefronts.
    do_clear();
    pc0 = pop_cnt; first_pop = -1;
    wave(6, 32'h200, 4'hF, 6, -1);
    drain("b2b_drain");
    chk("b2b_rows", DW'(pop_cnt - pc0), DW'(6));
    chk("b2b_consecutive", DW'(last_pop - first_pop), DW'(5));
    chk("b2b_ovf", overflow_o, 1'b0);
    chk("b2b_mis", misalign_o, 1'b0);

    // Enable-pattern table.
    for (int i = 0; i < 6; i++) begin
      do_clear();
      chk("tbl_clear_mis", misalign_o, 1'b0);
      chk("tbl_clear_idx", DW'(row_idx_o), '0);
      chk("tbl_clear_valid", out_valid_o, 1'b0);
      out_ready_i = 1'b1;
      wave(1, 32'h900 + 32'(i * 'h40), tbl[i].mask, tbl[i].n_store, -1);
      drain("tbl_drain");
      chk("tbl_misalign", misalign_o, tbl[i].exp_mis);
      chk("tbl_ovf", overflow_o, 1'b0);
    end

    // Backpressure: four stored, fifth dropped.
    do_clear();
    out_ready_i = 1'b0;
    wave(5, 32'h300, 4'hF, 4, -1);
    chk("bp_full", full_o, 1'b1);
    chk("bp_ovf", overflow_o, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("bp_stall_valid", out_valid_o, 1'b1);
      chk("bp_stall_data", out_data_o, exp_q[0].dat);
      chk("bp_stall_idx", DW'(row_idx_o), DW'(exp_q[0].idx));
      step();
    end
    out_ready_i = 1'b1;
    drain("bp_drain");
    chk("bp_full_after", full_o, 1'b0);
    chk("bp_ovf_sticky", overflow_o, 1'b1);

    // Full FIFO accepts a new row when popped in the same cycle.
    do_clear();
    out_ready_i = 1'b0;
    wave(4, 32'h400, 4'hF, 4, -1);
    chk("fp_full_before", full_o, 1'b1);
    wave(1, 32'h500, 4'hF, 1, 3);
    out_ready_i = 1'b0;
    chk("fp_full_kept", full_o, 1'b1);
    chk("fp_no_ovf", overflow_o, 1'b0);
    out_ready_i = 1'b1;
    drain("fp_drain");
    chk("fp_no_ovf_end", overflow_o, 1'b0);

    // Reset mid-stream with two rows queued and a wavefront in flight.
    do_clear();
    out_ready_i = 1'b0;
    wave(2, 32'h600, 4'hF, 2, -1);
    chk("rm_queued", out_valid_o, 1'b1);
    for (int t = 0; t < NC; t++) begin
      for (int c = 0; c < NC; c++) begin
        psum_i[c*PW +: PW] = (t == c) ? PW'(32'h700 + c) : '0;
        psum_en_i[c]       = (t == c);
      end
      rst_n = (t != 2);
      step();
      if (t == 2) begin
        exp_q.delete();
        exp_row = '0;
        chk("rm_valid", out_valid_o, 1'b0);
        chk("rm_full", full_o, 1'b0);
        chk("rm_data", out_data_o, '0);
        chk("rm_idx", DW'(row_idx_o), '0);
        chk("rm_ovf", overflow_o, 1'b0);
        chk("rm_mis", misalign_o, 1'b0);
      end
    end
    psum_i = '0; psum_en_i = '0;
    step();
    chk("rm_partial_mis", misalign_o, 1'b1);
    chk("rm_no_row", out_valid_o, 1'b0);
    out_ready_i = 1'b1;
    wave(1, 32'h800, 4'hF, 1, -1);
    drain("rm_restart_drain");
    chk("rm_mis_sticky", misalign_o, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
